qspi_line_fill: RTL
===================

# qspi_line_fill

Cache-line transfer sequencer sitting directly upstream of the QSPI pin controller. It arbitrates instruction-cache fills and data-cache fills/write-backs, drives the controller's request/address fields, assembles received nibbles into a full cache line, and serves write-back nibbles on demand. It completes each transfer by counting nibbles, because the controller provides no done signal.

## Interface
- `LINE_LENGTH`, 4: cache line length in bytes (power of two, ≥2).
- `PA`, 24: physical address width.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  I-cache fill request, level; held until `i_ack`.
- `i_mem`  in  2  chip select index for the I request.
- `i_addr`  in  PA-log2(LINE_LENGTH)  I line address.
- `i_ack`  out  1  one-cycle pulse: I fill complete, `rdata` valid.
- `d_req`  in  1  D request, level; held until `d_ack`.
- `d_write`  in  1  1 = write-back, 0 = fill.
- `d_mem`  in  2  chip select index for the D request.
- `d_addr`  in  PA-log2(LINE_LENGTH)  D line address.
- `d_wdata`  in  8*LINE_LENGTH  write-back line; byte b at [8b+7:8b]; held until `d_ack`.
- `d_ack`  out  1  one-cycle pulse: D transfer complete.
- `rdata`  out  8*LINE_LENGTH  assembled fill line.
- `req`, `i_d`, `write`  out  1 each  to controller.
- `mem`  out  2  to controller.
- `paddr`  out  PA-log2(LINE_LENGTH)  to controller.
- `dwrite`  out  4  write nibble to controller.
- `rstrobe_d`  in  1  controller consumed `dwrite` this cycle.
- `wstrobe_i`, `wstrobe_d`  in  1 each  read nibble valid on `uio_in` this cycle.
- `uio_in`  in  4  QSPI data pins.

## Operation
- States: IDLE, FILL, WB, ACK.
- **IDLE:** a grant is made when `d_req` or `i_req` is high. On grant:
  - register `i_d`, `mem`, `write`, `paddr` from the winner;
  - set `req=1`, `idx=0`;
  - go to FILL (`write=0`) or WB (`write=1`).
  - `i_d=1` only for I grants; I grants always have `write=0`.
- **Nibble order:** `idx` runs 0..2*LINE_LENGTH-1.
  - Byte b = `idx>>1`.
  - Even `idx` = high nibble [8b+7:8b+4]; odd `idx` = low nibble [8b+3:8b].
- **FILL:**
  - On each cycle where the selected strobe (`wstrobe_i` if `i_d`, else `wstrobe_d`) is high, write `uio_in` into `rdata` nibble `idx` and increment `idx`.
  - The opposite strobe is ignored.
  - `req` drops on the first accepted strobe.
  - After the nibble at `idx=2*LINE_LENGTH-1`, go to ACK.
- **WB:**
  - `dwrite` is combinationally `d_wdata` nibble `idx`.
  - `idx` increments on each cycle where `rstrobe_d` is high.
  - `req` drops on the first `rstrobe_d`.
  - After the last nibble is consumed, go to ACK.
- **ACK:**
  - pulse `i_ack` or `d_ack` for the granted side;
  - `req=0`;
  - go to IDLE.
- `i_d`, `mem`, `write`, `paddr` are stable from grant through ACK.
- `rdata` holds its value until the next FILL overwrites it.
- `dwrite` is 0 outside WB.
- Strobes arriving in IDLE or ACK are ignored.
- **Reset:**
  - IDLE, `idx=0`, `req=0`, `i_ack=0`, `d_ack=0`, `i_d=0`, `write=0`, `mem=0`, `paddr=0`, `rdata=0`;
  - a reset mid-transfer abandons the transfer with no ack.

## Timing
- A request seen in IDLE at cycle T gives `req=1` with valid fields at T+1.
- `req` stays high until the first strobe. This is needed because the controller may still be in its power-up sequence. Once the controller leaves idle it ignores `req`, so there is no retrigger.
- A fill's ack rises the cycle after the final strobe. `rdata` is complete in that same cycle.
- A write-back's ack rises the cycle after the final `rstrobe_d`.
- After an ack cycle, IDLE can grant at the next cycle. A requester that drops its request in the ack cycle is not re-granted.
- Requests are sampled only in IDLE. Changes to a request while another transfer is active have no effect.

## Configuration
- `QSPI_FILL_RR_EN`
  - **Defined:** round-robin arbitration. A 1-bit `last` register records the last granted side. On simultaneous `i_req` and `d_req`, the side not granted last wins. `last` resets to I, so D wins the first tie.
  - **Undefined:** fixed priority, D always wins ties. No `last` register exists.

## Test plan
- **Reset, then fill:**
  - `i_req`, `i_addr=0x123456>>2`, `i_mem=1`;
  - stimulus: 8 `wstrobe_i` pulses with `uio_in` = 1,2,…,8;
  - required: `rdata=0x78563412`, `i_ack` pulse one cycle after the 8th strobe, `i_d=1`, `paddr` stable throughout.
- **D write-back:**
  - `d_wdata=0xDEADBEEF`, `rstrobe_d` held high 8 cycles;
  - required: `dwrite` sequence E,F,B,E,A,D,D,E; `d_ack` one cycle after the last strobe.
- **Simultaneous `i_req` and `d_req` in three back-to-back rounds:**
  - with `QSPI_FILL_RR_EN` defined: grant order D, I, D;
  - without it: D, D, D.
- **Delayed controller start:**
  - `req` stays high 20 cycles with no strobes, then strobes arrive;
  - required: `req` drops on the first strobe and the fill completes normally.
- **Wrong-side strobe:** a `wstrobe_d` pulse during an I fill leaves `idx` and `rdata` unchanged.
- **Reset mid-transfer:** `reset` after 3 nibbles;
  - required: IDLE, `req=0`, no ack;
  - a new request afterwards completes all 8 nibbles.

Source files
------------

// File: rtl/qspi_line_fill.sv
// ============================================================================
//  Module   : qspi_line_fill
//  Purpose  : Cache-line transfer sequencer in front of the QSPI pin
//             controller. Arbitrates I-cache fills against D-cache
//             fills/write-backs, presents request fields to the controller,
//             assembles fill nibbles into a line and serves write-back
//             nibbles. Transfers end by nibble count.
//  Options  : QSPI_FILL_RR_EN - round-robin I/D arbitration when defined,
//             fixed D-priority otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qspi_line_fill #(
  parameter int LINE_LENGTH = 4,
  parameter int PA          = 24
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_req,
  input  logic [1:0]                         i_mem,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]  i_addr,
  output logic                               i_ack,
  input  logic                               d_req,
  input  logic                               d_write,
  input  logic [1:0]                         d_mem,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]  d_addr,
  input  logic [8*LINE_LENGTH-1:0]           d_wdata,
  output logic                               d_ack,
  output logic [8*LINE_LENGTH-1:0]           rdata,
  output logic                               req,
  output logic                               i_d,
  output logic                               write,
  output logic [1:0]                         mem,
  output logic [PA-$clog2(LINE_LENGTH)-1:0]  paddr,
  output logic [3:0]                         dwrite,
  input  logic                               rstrobe_d,
  input  logic                               wstrobe_i,
  input  logic                               wstrobe_d,
  input  logic [3:0]                         uio_in
);

  localparam int NIBBLES = 2 * LINE_LENGTH;
  localparam int IW      = $clog2(NIBBLES);
  localparam int OW      = $clog2(8 * LINE_LENGTH);

  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [OW-1:0] nib_off;
  logic          grant_d;
  logic          fill_strobe;
  logic          any_req;

  // Bit offset of nibble idx: byte idx>>1, high nibble first within a byte.
  assign nib_off     = {idx[IW-1:1], ~idx[0], 2'b00};
  assign any_req     = i_req | d_req;
  assign fill_strobe = i_d ? wstrobe_i : wstrobe_d;

`ifdef QSPI_FILL_RR_EN
  logic last;  // 1 = D side was granted most recently

  // On a tie, grant the side that was not granted last.
  always_comb begin
    grant_d = d_req & ~(i_req & last);
  end

  // Remember the winner of every grant for the next tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b0;
    end else if (state == S_IDLE && any_req) begin
      last <= grant_d;
    end
  end
`else
  // Fixed priority: D wins whenever it requests.
  always_comb begin
    grant_d = d_req;
  end
`endif

  // Transfer sequencer: grant, count nibbles, ack, return to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      req   <= 1'b0;
      i_d   <= 1'b0;
      write <= 1'b0;
      mem   <= 2'd0;
      paddr <= '0;
      rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            req   <= 1'b1;
            idx   <= '0;
            i_d   <= ~grant_d;
            write <= grant_d & d_write;
            mem   <= grant_d ? d_mem  : i_mem;
            paddr <= grant_d ? d_addr : i_addr;
            state <= (grant_d && d_write) ? S_WB : S_FILL;
          end
        end
        S_FILL: begin
          if (fill_strobe) begin
            rdata[nib_off +: 4] <= uio_in;
            req <= 1'b0;
            idx <= idx + IW'(1);
            if (idx == LAST_IDX) state <= S_ACK;
          end
        end
        S_WB: begin
          if (rstrobe_d) begin
            req <= 1'b0;
            idx <= idx + IW'(1);
            if (idx == LAST_IDX) state <= S_ACK;
          end
        end
        default: begin
          req   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Write-back nibble is served combinationally; quiet outside WB.
  always_comb begin
    dwrite = 4'd0;
    if (state == S_WB) dwrite = d_wdata[nib_off +: 4];
  end

  assign i_ack = (state == S_ACK) &  i_d;
  assign d_ack = (state == S_ACK) & ~i_d;

endmodule

`default_nettype wire
